// File: rtl/quat_gyro_integrator.sv
// quat_gyro_integrator: integrates Q8.8 gyro rates into a quaternion, q += 0.5*(q x w)*dt, one shared multiplier.
// Define QUAT_INT_SATURATE_EN to clamp updated components instead of wrapping.
module quat_gyro_integrator #(
  parameter int DT_SHIFT = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] gyro_x,
  input  logic [15:0] gyro_y,
  input  logic [15:0] gyro_z,
  input  logic        q_load,
  input  logic [15:0] load_w,
  input  logic [15:0] load_i,
  input  logic [15:0] load_j,
  input  logic [15:0] load_k,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] w_out,
  output logic [15:0] i_out,
  output logic [15:0] j_out,
  output logic [15:0] k_out
);
  typedef enum logic [1:0] {S_IDLE, S_MAC, S_UPDATE, S_OUT} state_t;
  state_t             r_state, w_next;
  logic signed [15:0] r_q [4];
  logic signed [15:0] r_g [3];
  logic signed [15:0] r_stg [4];
  logic signed [33:0] r_acc;
  logic [1:0]         r_grp, r_sub;
  logic [1:0]         w_qa, w_gb;
  logic               w_neg;
  logic signed [31:0] w_prod;
  logic signed [33:0] w_pext, w_acc;
  logic signed [17:0] w_delta, w_sum;
  logic [15:0]        w_res;
  logic               w_last;
  assign w_out = r_q[0];
  assign i_out = r_q[1];
  assign j_out = r_q[2];
  assign k_out = r_q[3];
  // Operand schedule for q (x) (0, x, y, z): {q index, gyro index, negate}, one group per output component
  always_comb begin
    {w_qa, w_gb, w_neg} = 5'b0;
    case ({r_grp, r_sub})
      4'h0: {w_qa, w_gb, w_neg} = {2'd1, 2'd0, 1'b1};
      4'h1: {w_qa, w_gb, w_neg} = {2'd2, 2'd1, 1'b1};
      4'h2: {w_qa, w_gb, w_neg} = {2'd3, 2'd2, 1'b1};
      4'h4: {w_qa, w_gb, w_neg} = {2'd0, 2'd0, 1'b0};
      4'h5: {w_qa, w_gb, w_neg} = {2'd2, 2'd2, 1'b0};
      4'h6: {w_qa, w_gb, w_neg} = {2'd3, 2'd1, 1'b1};
      4'h8: {w_qa, w_gb, w_neg} = {2'd0, 2'd1, 1'b0};
      4'h9: {w_qa, w_gb, w_neg} = {2'd1, 2'd2, 1'b1};
      4'hA: {w_qa, w_gb, w_neg} = {2'd3, 2'd0, 1'b0};
      4'hC: {w_qa, w_gb, w_neg} = {2'd0, 2'd2, 1'b0};
      4'hD: {w_qa, w_gb, w_neg} = {2'd1, 2'd1, 1'b0};
      4'hE: {w_qa, w_gb, w_neg} = {2'd2, 2'd0, 1'b1};
      default: {w_qa, w_gb, w_neg} = 5'b0;
    endcase
  end
  assign w_prod  = r_q[w_qa] * r_g[(w_gb == 2'd3) ? 2'd0 : w_gb];
  assign w_pext  = 34'(w_prod);
  assign w_acc   = r_acc + (w_neg ? -w_pext : w_pext);
  assign w_delta = 18'(w_acc >>> (9 + DT_SHIFT));
  assign w_sum   = {{2{r_q[r_grp][15]}}, r_q[r_grp]} + w_delta;
  assign w_last  = (r_grp == 2'd3) && (r_sub == 2'd2);
`ifdef QUAT_INT_SATURATE_EN
  assign w_res = (w_sum[17:15] == 3'b000 || w_sum[17:15] == 3'b111) ? w_sum[15:0] :
                 (w_sum[17] ? 16'h8000 : 16'h7FFF);
`else
  assign w_res = w_sum[15:0];
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_q     <= '{16'sh0100, 16'sh0, 16'sh0, 16'sh0};
      r_g     <= '{16'sh0, 16'sh0, 16'sh0};
      r_stg   <= '{16'sh0, 16'sh0, 16'sh0, 16'sh0};
      r_acc   <= '0;
      r_grp   <= '0;
      r_sub   <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (q_load) r_q <= '{load_w, load_i, load_j, load_k};
          else if (in_valid) begin
            r_g   <= '{gyro_x, gyro_y, gyro_z};
            r_acc <= '0;
            r_grp <= '0;
            r_sub <= '0;
          end
        end
        S_MAC: begin
          if (r_sub == 2'd2) begin
            r_stg[r_grp] <= w_res;
            r_acc        <= '0;
            r_sub        <= '0;
            r_grp        <= r_grp + 2'd1;
          end else begin
            r_acc <= w_acc;
            r_sub <= r_sub + 2'd1;
          end
        end
        S_UPDATE: r_q <= r_stg;
        default: ;
      endcase
    end
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = (!q_load && in_valid) ? S_MAC : S_IDLE;
      S_MAC:    w_next = w_last ? S_UPDATE : S_MAC;
      S_UPDATE: w_next = S_OUT;
      S_OUT:    w_next = out_ready ? S_IDLE : S_OUT;
      default:  w_next = S_IDLE;
    endcase
  end
  always_comb begin
    in_ready  = (r_state == S_IDLE) && !q_load;
    out_valid = (r_state == S_OUT);
  end
endmodule

// File: tb/tb_quat_gyro_integrator.sv
// tb_quat_gyro_integrator: directed bench with a quaternion-kinematics reference model and per-cycle output compare.
module tb_quat_gyro_integrator;
  logic        clk = 0, rst_n = 0;
  logic        in_valid = 0, in_ready, q_load = 0, out_valid, out_ready = 0;
  logic [15:0] gyro_x = 0, gyro_y = 0, gyro_z = 0;
  logic [15:0] load_w = 0, load_i = 0, load_j = 0, load_k = 0;
  logic [15:0] w_out, i_out, j_out, k_out;
  int          checks = 0, failures = 0;
  logic [63:0] mq = 64'h0100_0000_0000_0000, prev = 64'h0100_0000_0000_0000;
  bit          busy = 0;

  quat_gyro_integrator dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .gyro_x(gyro_x), .gyro_y(gyro_y), .gyro_z(gyro_z), .q_load(q_load),
    .load_w(load_w), .load_i(load_i), .load_j(load_j), .load_k(load_k),
    .out_valid(out_valid), .out_ready(out_ready),
    .w_out(w_out), .i_out(i_out), .j_out(j_out), .k_out(k_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic longint sx(input logic [15:0] v);
    return longint'($signed(v));
  endfunction

  function automatic logic [15:0] fit(input longint v);
`ifdef QUAT_INT_SATURATE_EN
    if (v > 32767) return 16'h7FFF;
    if (v < -32768) return 16'h8000;
`endif
    return v[15:0];
  endfunction

  // q' = q + floor(0.5 * dt * (q (x) (0,w))) with dt = 1/128, all in Q8.8
  function automatic logic [63:0] model(input logic [63:0] q, input logic [15:0] gx, gy, gz);
    longint w, i, j, k, x, y, z, dw, di, dj, dk;
    w = sx(q[63:48]); i = sx(q[47:32]); j = sx(q[31:16]); k = sx(q[15:0]);
    x = sx(gx); y = sx(gy); z = sx(gz);
    dw = -(i * x + j * y + k * z);
    di = w * x + j * z - k * y;
    dj = w * y + k * x - i * z;
    dk = w * z + i * y - j * x;
    return {fit(w + (dw >>> 16)), fit(i + (di >>> 16)), fit(j + (dj >>> 16)), fit(k + (dk >>> 16))};
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      chk(out_valid ? "q_out" : (busy ? "q_hold" : "q_idle"), {w_out, i_out, j_out, k_out},
          (busy && !out_valid) ? prev : mq);
      if (out_valid) chk("in_ready_out", 64'(in_ready), 64'd0);
    end
  end

  task automatic do_load(input logic [15:0] w, i, j, k, input logic v);
    @(negedge clk);
    q_load = 1; {load_w, load_i, load_j, load_k} = {w, i, j, k}; in_valid = v;
    #1 chk("in_ready_load", 64'(in_ready), 64'd0);
    @(posedge clk);
    mq = {w, i, j, k}; prev = mq;
    #1 q_load = 0;
  endtask

  task automatic run_sample(input logic [15:0] gx, gy, gz, input int hold);
    int n;
    @(negedge clk);
    in_valid = 1; {gyro_x, gyro_y, gyro_z} = {gx, gy, gz};
    #1 chk("in_ready_idle", 64'(in_ready), 64'd1);
    @(posedge clk);
    prev = mq; mq = model(mq, gx, gy, gz); busy = 1;
    #1 in_valid = 0;
    n = 1;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      #1 n++;
    end
    chk("latency", 64'(n), 64'd14);
    repeat (hold) begin
      @(negedge clk);
      chk("ov_held", 64'(out_valid), 64'd1);
    end
    @(negedge clk) out_ready = 1;
    @(posedge clk);
    busy = 0;
    #1 out_ready = 0;
    chk("ov_drop", 64'(out_valid), 64'd0);
  endtask

  initial begin
    #17 chk("rst_q", {w_out, i_out, j_out, k_out}, 64'h0100_0000_0000_0000);
    chk("rst_ov", 64'(out_valid), 64'd0);
    @(negedge clk) rst_n = 1;
    #1 chk("rst_ready", 64'(in_ready), 64'd1);

    run_sample(16'h0100, 16'h0000, 16'h0000, 0);
    chk("x_rate_lit", {w_out, i_out, j_out, k_out}, 64'h0100_0001_0000_0000);

    do_load(16'h0100, 16'h0000, 16'h0000, 16'h0000, 0);
    run_sample(16'h0000, 16'h0000, 16'hFF00, 0);
    chk("negz_lit", {w_out, k_out}, {16'h0100, 16'hFFFF});

    do_load(16'h0100, 16'h0000, 16'h0000, 16'h0000, 1);
    run_sample(16'h0300, 16'hFE80, 16'h0040, 5);
    run_sample(16'h0000, 16'h0000, 16'h0000, 2);
    run_sample(16'h1000, 16'h2000, 16'hE000, 0);
    run_sample(16'hF000, 16'h0800, 16'h7FFF, 1);

    do_load(16'h7FFF, 16'h8000, 16'h0000, 16'h0000, 0);
    run_sample(16'h7FFF, 16'h0000, 16'h0000, 0);
`ifdef QUAT_INT_SATURATE_EN
    chk("ovf_w_lit", 64'(w_out), 64'h7FFF);
`else
    chk("ovf_w_lit", 64'(w_out), 64'hBFFE);
`endif
    chk("ovf_i_lit", 64'(i_out), 64'hBFFF);

    @(negedge clk);
    in_valid = 1; {gyro_x, gyro_y, gyro_z} = {16'h0100, 16'h0000, 16'h0100};
    @(posedge clk);
    prev = mq; busy = 1;
    #1 in_valid = 0;
    repeat (5) @(posedge clk);
    #2 rst_n = 0;
    #1 chk("midrst_q", {w_out, i_out, j_out, k_out}, 64'h0100_0000_0000_0000);
    chk("midrst_ov", 64'(out_valid), 64'd0);
    mq = 64'h0100_0000_0000_0000; prev = mq; busy = 0;
    @(negedge clk) rst_n = 1;
    run_sample(16'h0100, 16'h0000, 16'h0000, 0);
    chk("post_rst_lit", {w_out, i_out, j_out, k_out}, 64'h0100_0001_0000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/quat_gyro_integrator.md
Name: quat_gyro_integrator

Overview:
- Integrates body-rate gyro samples into an orientation quaternion using q += 0.5·(q ⊗ ω)·dt.
- Sits directly upstream of the quaternion normaliser. Its w/i/j/k outputs feed the normaliser inputs.
- The normalised result is written back through the load port.
- All quaternion and rate values are signed Q8.8, 16-bit. A single shared multiplier is time-multiplexed by an FSM.

Parameters:
- DT_SHIFT, 7, sample period dt = 2^-DT_SHIFT s (7 → 1/128 s).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  gyro sample valid.
- in_ready  out  1  block can accept a sample.
- gyro_x, gyro_y, gyro_z  in  16 each  angular rate, signed Q8.8 rad/s.
- q_load  in  1  load quaternion state from load_* (1-cycle pulse).
- load_w, load_i, load_j, load_k  in  16 each  quaternion to load, Q8.8 (normaliser output).
- out_valid  out  1  updated quaternion available.
- out_ready  in  1  downstream accepts quaternion.
- w_out, i_out, j_out, k_out  out  16 each  current quaternion state, Q8.8.

Behaviour:
- Reset (async, rst_n=0): state IDLE, w_out=0x0100, i_out=j_out=k_out=0x0000, out_valid=0, in_ready=1 after release. Accumulator, step counter and staged registers are cleared.
- Reset asserted mid-operation aborts immediately. The partial result is discarded.
- State machine IDLE → MAC → UPDATE → OUT → IDLE.
- IDLE:
  - in_ready = !q_load.
  - If q_load=1, q ← load_*, and any in_valid that cycle is not accepted.
  - Else if in_valid=1, gyro_x/y/z are captured and the FSM goes to MAC.
- MAC: exactly 12 cycles, one signed 16×16→32 product per cycle (Q16.16), into a 34-bit accumulator. Order and sign, using the old q:
  - w: -x·i, -y·j, -z·k
  - i: +w·x, +j·z, -k·y
  - j: +w·y, -i·z, +k·x
  - k: +w·z, +i·y, -j·x
- After each group of 3 products:
  - delta = acc >>> (9 + DT_SHIFT), arithmetic, floor.
  - staged_c = q_c + delta, computed in 18 bits and reduced to 16 bits (see Optional Feature).
  - The accumulator is then cleared.
- UPDATE: 1 cycle. All four staged values commit to q simultaneously, then the FSM goes to OUT.
- OUT:
  - out_valid=1; w/i/j/k_out stable.
  - The FSM stays in OUT while out_ready=0.
  - When out_ready=1, out_valid drops next edge and the FSM returns to IDLE.
- Latency: counting the accepting edge as edge 1, out_valid rises after edge 14. Minimum throughput is one sample per 15 cycles.
- in_ready=0 in MAC, UPDATE and OUT. q_load is ignored outside IDLE.
- Outputs always reflect the current q register. q changes only at reset, at a load in IDLE, or at UPDATE.

Optional Feature:
- Macro: QUAT_INT_SATURATE_EN.
- Defined: each 18-bit staged sum clamps to 0x7FFF / 0x8000 on overflow.
- Undefined: the low 16 bits are kept (two's-complement wrap).

Test Plan:
- Reset check: assert rst_n=0, then release → w_out=0x0100, i/j/k_out=0, out_valid=0, in_ready=1.
- Pure x-rate from identity: gyro=(0x0100,0,0) accepted, out_ready=1 → out_valid after 14 edges, w=0x0100, i=0x0001, j=k=0x0000.
- Negative z-rate plus simultaneous events:
  - From identity, gyro_z=0xFF00 (-1.0) → k_out=0xFFFF, w=0x0100.
  - Then assert q_load (load=(0x0100,0,0,0)) together with in_valid in IDLE → load taken, in_ready=0 that cycle.
  - The sample is accepted on the following cycle.
- Backpressure and zero rate: hold out_ready=0 for 5 cycles after out_valid → out_valid and outputs stay stable, in_ready=0. A zero-rate sample then leaves q unchanged.
- Overflow: load (0x7FFF,0x8000,0,0), gyro=(0x7FFF,0,0) → w_out=0x7FFF with QUAT_INT_SATURATE_EN, 0xBFFE without; i_out=0xBFFF in both.
- Reset mid-operation: drop rst_n during MAC cycle 6 → immediate return to the reset values. The next sample produces the same result as a first sample from identity.
